// File: rtl/hangman_pkg.sv
// Shared types and ASCII helpers for the hangman game controller.
package hangman_pkg;

  typedef enum logic [2:0] {
    SETUP = 3'd0,
    PLAY  = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_e;

  localparam logic [7:0]  ASCII_A = 8'h41;
  localparam logic [7:0]  ASCII_Z = 8'h5A;
  localparam int unsigned ALPHA_N = 26;

  function automatic logic is_alpha(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    logic [7:0] d;
    d = c - ASCII_A;
    return d[4:0];
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_match.sv
// Combinational compare of one guessed letter against every letter of the word.
module hangman_match #(
  parameter int unsigned WORD_LEN = 5
) (
  input  logic [8*WORD_LEN-1:0] word,
  input  logic [7:0]            letter,
  output logic [WORD_LEN-1:0]   match
);

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      match[i] = (word[8*i +: 8] == letter);
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: captures the secret word, judges guesses, tracks reveal
// mask / mistakes / guessed letters and drives win/lose and the status LED.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN     = 5,
  parameter int unsigned MAX_MISTAKES = 6,
  parameter int unsigned CW           = 3
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic [7:0]            host_letter,
  input  logic                  host_letter_valid,
  input  logic                  host_word_submit,
  input  logic [7:0]            guess_letter,
  input  logic                  guess_valid,
  input  logic                  restart,
  output logic [8*WORD_LEN-1:0] word,
  output logic [2:0]            letter_cnt,
  output logic [WORD_LEN-1:0]   mask,
  output logic [CW-1:0]         mistakes,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  win,
  output logic                  lose,
  output logic                  red,
  output logic                  green,
  output logic                  blue,
  output logic                  error,
  output logic                  dup
);

  localparam logic [2:0]    LEN_C = 3'(WORD_LEN);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_MISTAKES);

  state_e                state_q, state_d;
  logic [8*WORD_LEN-1:0] word_q, word_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [WORD_LEN-1:0]   mask_q, mask_d;
  logic [CW-1:0]         mistakes_q, mistakes_d;
  logic [ALPHA_N-1:0]    guessed_q, guessed_d;
  logic [7:0]            guess_q, guess_d;
  logic                  red_q, red_d, green_q, green_d;
  logic                  error_q, error_d, dup_q, dup_d;
  logic [WORD_LEN-1:0]   match;

  hangman_match #(.WORD_LEN(WORD_LEN)) u_match (
    .word   (word_q),
    .letter (guess_q),
    .match  (match)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= SETUP;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      word_q     <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      mistakes_q <= '0;
      guessed_q  <= '0;
      guess_q    <= '0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      error_q    <= 1'b0;
      dup_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      mistakes_q <= mistakes_d;
      guessed_q  <= guessed_d;
      guess_q    <= guess_d;
      red_q      <= red_d;
      green_q    <= green_d;
      error_q    <= error_d;
      dup_q      <= dup_d;
    end
  end

  // Datapath updates; the next-state logic reads the updated mask/mistakes.
  always_comb begin
    word_d     = word_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    mistakes_d = mistakes_q;
    guessed_d  = guessed_q;
    guess_d    = guess_q;
    red_d      = red_q;
    green_d    = green_q;
    error_d    = 1'b0;
    dup_d      = 1'b0;
    if (restart) begin
      word_d     = '0;
      cnt_d      = '0;
      mask_d     = '0;
      mistakes_d = '0;
      guessed_d  = '0;
      red_d      = 1'b0;
      green_d    = 1'b0;
    end else begin
      case (state_q)
        SETUP: begin
          if (host_letter_valid) begin
            if (!is_alpha(host_letter) || cnt_q == LEN_C) begin
              error_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < WORD_LEN; i++) begin
                if (3'(i) == cnt_q) word_d[8*i +: 8] = host_letter;
              end
              cnt_d = cnt_q + 3'd1;
            end
          end
          // Submit is judged on the count before any same-cycle capture.
          if (host_word_submit) begin
            if (cnt_q != LEN_C) begin
              error_d = 1'b1;
            end else begin
              mask_d     = '0;
              mistakes_d = '0;
              guessed_d  = '0;
              red_d      = 1'b0;
              green_d    = 1'b0;
            end
          end
        end
        PLAY: begin
          if (guess_valid) begin
            if (is_alpha(guess_letter)) guess_d = guess_letter;
            else                        error_d = 1'b1;
          end
        end
        CHECK: begin
          if (guessed_q[letter_idx(guess_q)]) begin
            dup_d = 1'b1;
          end else begin
            guessed_d[letter_idx(guess_q)] = 1'b1;
            mask_d = mask_q | match;
            if (|match) begin
              green_d = 1'b1;
              red_d   = 1'b0;
            end else begin
              if (mistakes_q != MAX_C) mistakes_d = mistakes_q + 1'b1;
              red_d   = 1'b1;
              green_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = SETUP;
    end else begin
      case (state_q)
        SETUP:   if (host_word_submit && cnt_q == LEN_C) state_d = PLAY;
        PLAY:    if (guess_valid && is_alpha(guess_letter)) state_d = CHECK;
        CHECK: begin
          if (&mask_d)                  state_d = WIN;
          else if (mistakes_d == MAX_C) state_d = LOSE;
          else                          state_d = PLAY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    word       = word_q;
    letter_cnt = cnt_q;
    mask       = mask_q;
    mistakes   = mistakes_q;
    phase      = state_q;
    busy       = (state_q == CHECK);
    win        = (state_q == WIN);
    lose       = (state_q == LOSE);
    blue       = (state_q == SETUP);
    red        = (state_q == LOSE) || ((state_q == PLAY || state_q == CHECK) && red_q);
    green      = (state_q == WIN)  || ((state_q == PLAY || state_q == CHECK) && green_q);
    error      = error_q;
    dup        = dup_q;
  end

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Directed self-checking bench for hangman_game_ctrl (word APPLE scenarios).
module tb_hangman_game_ctrl;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [7:0]  host_letter = '0;
  logic        host_letter_valid = 1'b0;
  logic        host_word_submit = 1'b0;
  logic [7:0]  guess_letter = '0;
  logic        guess_valid = 1'b0;
  logic        restart = 1'b0;
  logic [39:0] word;
  logic [2:0]  letter_cnt;
  logic [4:0]  mask;
  logic [2:0]  mistakes;
  logic [2:0]  phase;
  logic        busy, win, lose, red, green, blue, error, dup;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [39:0] APPLE = 40'h45_4C_50_50_41;

  hangman_game_ctrl #(.WORD_LEN(5), .MAX_MISTAKES(6), .CW(3)) dut (
    .clk(clk), .nRst(nRst),
    .host_letter(host_letter), .host_letter_valid(host_letter_valid),
    .host_word_submit(host_word_submit),
    .guess_letter(guess_letter), .guess_valid(guess_valid), .restart(restart),
    .word(word), .letter_cnt(letter_cnt), .mask(mask), .mistakes(mistakes),
    .phase(phase), .busy(busy), .win(win), .lose(lose),
    .red(red), .green(green), .blue(blue), .error(error), .dup(dup)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: assert on a falling edge, release on the next one.
  task automatic send_host(input logic [7:0] c);
    @(negedge clk); host_letter = c; host_letter_valid = 1'b1;
    @(negedge clk); host_letter_valid = 1'b0;
  endtask

  task automatic send_submit();
    @(negedge clk); host_word_submit = 1'b1;
    @(negedge clk); host_word_submit = 1'b0;
  endtask

  task automatic send_guess(input logic [7:0] c);
    @(negedge clk); guess_letter = c; guess_valid = 1'b1;
    @(negedge clk); guess_valid = 1'b0;
  endtask

  task automatic send_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic load_apple();
    send_host(8'h41); send_host(8'h50); send_host(8'h50);
    send_host(8'h4C); send_host(8'h45);
    send_submit();
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    #12;
    n_vec++;
    if ({word, letter_cnt, mask, mistakes, phase} !== 54'd0) begin
      n_err++; $display("FAIL reset_regs: got %h required 0", {word, letter_cnt, mask, mistakes, phase});
    end
    n_vec++;
    if ({win, lose, error, dup, red, green, blue, busy} !== 8'b0000_0010) begin
      n_err++; $display("FAIL reset_flags: got %b required 00000010", {win, lose, error, dup, red, green, blue, busy});
    end
    @(negedge clk); nRst = 1'b1;
  endtask

  task automatic test_setup();
    send_host(8'h41); send_host(8'h50); send_host(8'h50);
    send_submit();
    n_vec++;
    if ({error, phase, letter_cnt} !== {1'b1, 3'd0, 3'd3}) begin
      n_err++; $display("FAIL short_submit: got err=%b phase=%0d cnt=%0d required 1 0 3", error, phase, letter_cnt);
    end
    send_host(8'h31);
    n_vec++;
    if ({error, letter_cnt} !== {1'b1, 3'd3}) begin
      n_err++; $display("FAIL bad_host_letter: got err=%b cnt=%0d required 1 3", error, letter_cnt);
    end
    send_host(8'h4C); send_host(8'h45);
    send_host(8'h58);
    n_vec++;
    if ({error, letter_cnt} !== {1'b1, 3'd5}) begin
      n_err++; $display("FAIL sixth_letter: got err=%b cnt=%0d required 1 5", error, letter_cnt);
    end
    n_vec++;
    if (word !== APPLE) begin
      n_err++; $display("FAIL word: got %h required %h", word, APPLE);
    end
    send_submit();
    n_vec++;
    if ({phase, mask, blue, error} !== {3'd1, 5'b00000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL submit_play: got phase=%0d mask=%b blue=%b err=%b required 1 00000 0 0", phase, mask, blue, error);
    end
  endtask

  task automatic test_guess();
    send_guess(8'h50);
    n_vec++;
    if ({busy, phase} !== {1'b1, 3'd2}) begin
      n_err++; $display("FAIL check_busy: got busy=%b phase=%0d required 1 2", busy, phase);
    end
    @(negedge clk);
    n_vec++;
    if ({mask, mistakes, green, red, busy} !== {5'b00110, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL hit_P: got mask=%b mis=%0d g=%b r=%b busy=%b required 00110 0 1 0 0", mask, mistakes, green, red, busy);
    end
    send_guess(8'h48); @(negedge clk);
    n_vec++;
    if ({mask, mistakes, green, red, phase} !== {5'b00110, 3'd1, 1'b0, 1'b1, 3'd1}) begin
      n_err++; $display("FAIL miss_H: got mask=%b mis=%0d g=%b r=%b phase=%0d required 00110 1 0 1 1", mask, mistakes, green, red, phase);
    end
  endtask

  task automatic test_dup_error();
    send_guess(8'h50); @(negedge clk);
    n_vec++;
    if ({dup, mistakes, mask, red} !== {1'b1, 3'd1, 5'b00110, 1'b1}) begin
      n_err++; $display("FAIL dup_P: got dup=%b mis=%0d mask=%b r=%b required 1 1 00110 1", dup, mistakes, mask, red);
    end
    @(negedge clk);
    n_vec++;
    if (dup !== 1'b0) begin
      n_err++; $display("FAIL dup_pulse_width: got %b required 0", dup);
    end
    send_guess(8'h31);
    n_vec++;
    if ({error, phase} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL bad_guess: got err=%b phase=%0d required 1 1", error, phase);
    end
    @(negedge clk);
    n_vec++;
    if ({error, phase, mistakes, mask} !== {1'b0, 3'd1, 3'd1, 5'b00110}) begin
      n_err++; $display("FAIL bad_guess_after: got err=%b phase=%0d mis=%0d mask=%b required 0 1 1 00110", error, phase, mistakes, mask);
    end
  endtask

  task automatic test_win();
    send_guess(8'h41); @(negedge clk);
    n_vec++;
    if ({mask, green, red} !== {5'b00111, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL hit_A: got mask=%b g=%b r=%b required 00111 1 0", mask, green, red);
    end
    send_guess(8'h45); @(negedge clk);
    send_guess(8'h4C); @(negedge clk);
    n_vec++;
    if ({mask, win, lose, green, red, blue, phase} !== {5'b11111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL win: got mask=%b win=%b lose=%b g=%b r=%b b=%b phase=%0d required 11111 1 0 1 0 0 3",
                        mask, win, lose, green, red, blue, phase);
    end
    send_guess(8'h5A); @(negedge clk);
    n_vec++;
    if ({phase, mistakes, mask, error} !== {3'd3, 3'd1, 5'b11111, 1'b0}) begin
      n_err++; $display("FAIL win_ignores: got phase=%0d mis=%0d mask=%b err=%b required 3 1 11111 0", phase, mistakes, mask, error);
    end
    send_restart();
    n_vec++;
    if ({phase, blue, red, green, win, word, letter_cnt, mask, mistakes} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 40'd0, 3'd0, 5'd0, 3'd0}) begin
      n_err++; $display("FAIL restart_win: got phase=%0d b=%b r=%b g=%b win=%b word=%h cnt=%0d mask=%b mis=%0d required all clear, blue",
                        phase, blue, red, green, win, word, letter_cnt, mask, mistakes);
    end
  endtask

  task automatic test_lose();
    logic [7:0] wrong [7];
    wrong = '{8'h42, 8'h43, 8'h44, 8'h46, 8'h47, 8'h48, 8'h49};
    send_host(8'h41); send_host(8'h50); send_host(8'h50); send_host(8'h4C);
    @(negedge clk); host_letter = 8'h45; host_letter_valid = 1'b1; host_word_submit = 1'b1;
    @(negedge clk); host_letter_valid = 1'b0; host_word_submit = 1'b0;
    n_vec++;
    if ({letter_cnt, error, phase, word} !== {3'd5, 1'b1, 3'd0, APPLE}) begin
      n_err++; $display("FAIL letter_and_submit: got cnt=%0d err=%b phase=%0d word=%h required 5 1 0 %h", letter_cnt, error, phase, word, APPLE);
    end
    send_submit();
    for (int i = 0; i < 7; i++) begin
      send_guess(wrong[i]); @(negedge clk);
      n_vec++;
      if ({lose, mistakes, red, green} !== {(i >= 5), 3'((i >= 5) ? 6 : i + 1), 1'b1, 1'b0}) begin
        n_err++; $display("FAIL lose_seq_%0d: got lose=%b mis=%0d r=%b g=%b required %b %0d 1 0",
                          i, lose, mistakes, red, green, (i >= 5), (i >= 5) ? 6 : i + 1);
      end
    end
    n_vec++;
    if ({phase, win, blue} !== {3'd4, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL lose_phase: got phase=%0d win=%b b=%b required 4 0 0", phase, win, blue);
    end
    send_restart();
  endtask

  task automatic test_restart_coincident();
    load_apple();
    @(negedge clk); guess_letter = 8'h41; guess_valid = 1'b1; restart = 1'b1;
    @(negedge clk); guess_valid = 1'b0; restart = 1'b0;
    n_vec++;
    if ({phase, letter_cnt, word, blue} !== {3'd0, 3'd0, 40'd0, 1'b1}) begin
      n_err++; $display("FAIL restart_vs_guess: got phase=%0d cnt=%0d word=%h b=%b required 0 0 0 1", phase, letter_cnt, word, blue);
    end
    @(negedge clk);
    n_vec++;
    if ({phase, busy, mask} !== {3'd0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL restart_discard: got phase=%0d busy=%b mask=%b required 0 0 0", phase, busy, mask);
    end
  endtask

  task automatic test_async_reset();
    load_apple();
    send_guess(8'h50); @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    n_vec++;
    if ({word, letter_cnt, mask, mistakes, phase, win, lose, error, dup, red, green, blue, busy} !==
        {40'd0, 3'd0, 5'd0, 3'd0, 3'd0, 8'b0000_0010}) begin
      n_err++; $display("FAIL async_reset: got word=%h cnt=%0d mask=%b mis=%0d phase=%0d flags=%b required all 0, blue=1",
                        word, letter_cnt, mask, mistakes, phase, {win, lose, error, dup, red, green, blue, busy});
    end
    @(negedge clk); nRst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_setup();
    test_guess();
    test_dup_error();
    test_win();
    test_lose();
    test_restart_coincident();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
